// File: rtl/inagu_pkg.sv
// inagu_pkg: shared widths and the FSM state encoding also decoded for the outagu
package inagu_pkg;
    localparam int BDBANKA_DEF = 15;
    localparam int BCNT_DEF    = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/inagu_if.sv
// inagu_if: MVU-side launch/step handshake, loop config and address outputs
interface inagu_if
    import inagu_pkg::*;
#(
    parameter int BDBANKA = BDBANKA_DEF,
    parameter int BCNT    = BCNT_DEF
);
    logic               start;
    logic               step;
    logic [BDBANKA-1:0] baseaddr;
    logic [BCNT-1:0]    len0;
    logic [BDBANKA-1:0] stride0;
    logic [BCNT-1:0]    len1;
    logic [BDBANKA-1:0] stride1;
    logic [BDBANKA-1:0] addrout;
    logic               valid;
    logic               last;
    logic               busy;
    logic               done;
    modport master (
        output start, step, baseaddr, len0, stride0, len1, stride1,
        input  addrout, valid, last, busy, done
    );
    modport slave (
        input  start, step, baseaddr, len0, stride0, len1, stride1,
        output addrout, valid, last, busy, done
    );
endinterface

// File: rtl/inagu_loopcnt.sv
// inagu_loopcnt: one loop level; counts 0..len and flags the final iteration
module inagu_loopcnt
    import inagu_pkg::*;
#(
    parameter int BCNT = BCNT_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            zero,
    input  logic            inc,
    input  logic [BCNT-1:0] len,
    output logic            wrap
);
    logic [BCNT-1:0] cnt;
    assign wrap = cnt == len;
    // reset and load-zero both restart the count; zero beats inc
    always_ff @(posedge clk) begin
        if (!clr_n || zero) cnt <= '0;
        else if (inc)       cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/inagu.sv
// inagu: input data memory read address generator walking a two-level strided loop
module inagu
    import inagu_pkg::*;
#(
    parameter int BDBANKA = BDBANKA_DEF,
    parameter int BCNT    = BCNT_DEF
) (
    input  logic     clk,
    input  logic     clr_n,
    inagu_if.slave   bus
);
    logic [1:0]         state, nxt;
    logic [BCNT-1:0]    len0_q, len1_q;
    logic [BDBANKA-1:0] stride0_q, stride1_q, rowbase, addr;
    logic               w0, w1, run, ld, adv, last;

    assign run  = state == ST_RUN;
    assign ld   = state == ST_IDLE && bus.start;
    assign last = run && w0 && w1;
    assign adv  = run && bus.step && !last;

    inagu_loopcnt #(.BCNT(BCNT)) u_inner (
        .clk(clk), .clr_n(clr_n), .zero(ld || (adv && w0)), .inc(adv && !w0),
        .len(len0_q), .wrap(w0)
    );
    inagu_loopcnt #(.BCNT(BCNT)) u_outer (
        .clk(clk), .clr_n(clr_n), .zero(ld), .inc(adv && w0),
        .len(len1_q), .wrap(w1)
    );

    // DONE and any stray encoding fall back to IDLE
    always_comb begin
        nxt = ld ? ST_RUN : (last && bus.step) ? ST_DONE : run ? ST_RUN : ST_IDLE;
    end

    // config capture on launch, then inner stride or jump to the next row base per step
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            rowbase   <= '0;
            len0_q    <= '0;
            len1_q    <= '0;
            stride0_q <= '0;
            stride1_q <= '0;
        end else begin
            state <= nxt;
            if (ld) begin
                addr      <= bus.baseaddr;
                rowbase   <= bus.baseaddr;
                len0_q    <= bus.len0;
                len1_q    <= bus.len1;
                stride0_q <= bus.stride0;
                stride1_q <= bus.stride1;
            end else if (adv) begin
                addr <= w0 ? rowbase + stride1_q : addr + stride0_q;
                if (w0) rowbase <= rowbase + stride1_q;
            end
        end
    end

    assign bus.addrout = addr;
    assign bus.valid   = run;
    assign bus.last    = last;
    assign bus.busy    = state != ST_IDLE;
    assign bus.done    = state == ST_DONE;
endmodule

// File: tb/tb_inagu.sv
// tb_inagu: directed vector table plus hand sequences for stall, single-address and start-while-busy
module tb_inagu;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int errs = 0;
    int checks = 0;

    inagu_if bus ();
    inagu dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rn, st, sp;
        logic [14:0] ba;
        logic [7:0]  l0;
        logic [14:0] s0;
        logic [7:0]  l1;
        logic [14:0] s1;
        logic        ca;
        logic [14:0] ea;
        logic        ev, el, eb, ed;
    } vec_t;

    function automatic vec_t mk(input logic rn, st, sp, input logic [14:0] ba, input logic [7:0] l0,
                                input logic [14:0] s0, input logic [7:0] l1, input logic [14:0] s1,
                                input logic ca, input logic [14:0] ea, input logic ev, el, eb, ed);
        vec_t v;
        v.rn = rn; v.st = st; v.sp = sp; v.ba = ba; v.l0 = l0; v.s0 = s0; v.l1 = l1; v.s1 = s1;
        v.ca = ca; v.ea = ea; v.ev = ev; v.el = el; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic put(input logic rn, st, sp, input logic [14:0] ba, input logic [7:0] l0,
                       input logic [14:0] s0, input logic [7:0] l1, input logic [14:0] s1);
        clr_n = rn; bus.start = st; bus.step = sp; bus.baseaddr = ba;
        bus.len0 = l0; bus.stride0 = s0; bus.len1 = l1; bus.stride1 = s1;
    endtask

    task automatic tick(input string nm, input logic ca, input logic [14:0] ea, input logic ev, el, eb, ed);
        logic [18:0] got, exp;
        @(posedge clk);
        #1;
        got = {ca ? bus.addrout : 15'd0, bus.valid, bus.last, bus.busy, bus.done};
        exp = {ca ? ea : 15'd0, ev, el, eb, ed};
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got addr=%h valid=%b last=%b busy=%b done=%b, want addr=%h valid=%b last=%b busy=%b done=%b",
                     nm, bus.addrout, bus.valid, bus.last, bus.busy, bus.done, ea, ev, el, eb, ed);
        end
    endtask

    initial begin
        vec_t tv[$];
        logic [14:0] seq[4];
        put(0, 0, 0, 0, 0, 0, 0, 0);
        // nested walk: 3 words x 2 rows
        tv.push_back(mk(0, 0, 0, 'h100, 2, 1, 1, 'h10, 1, 'h000, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 'h100, 2, 1, 1, 'h10, 1, 'h100, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h100, 2, 1, 1, 'h10, 1, 'h101, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h100, 2, 1, 1, 'h10, 1, 'h102, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h100, 2, 1, 1, 'h10, 1, 'h110, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h100, 2, 1, 1, 'h10, 1, 'h111, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h100, 2, 1, 1, 'h10, 1, 'h112, 1, 1, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h100, 2, 1, 1, 'h10, 0, 'h000, 0, 0, 1, 1));
        tv.push_back(mk(1, 0, 0, 'h100, 2, 1, 1, 'h10, 0, 'h000, 0, 0, 0, 0));
        // wrap past the top of the bank
        tv.push_back(mk(1, 1, 0, 'h7FFE, 3, 1, 0, 'h100, 1, 'h7FFE, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h7FFE, 3, 1, 0, 'h100, 1, 'h7FFF, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h7FFE, 3, 1, 0, 'h100, 1, 'h0000, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h7FFE, 3, 1, 0, 'h100, 1, 'h0001, 1, 1, 1, 0));
        tv.push_back(mk(1, 0, 1, 'h7FFE, 3, 1, 0, 'h100, 0, 'h0000, 0, 0, 1, 1));
        tv.push_back(mk(1, 0, 0, 'h7FFE, 3, 1, 0, 'h100, 0, 'h0000, 0, 0, 0, 0));
        // reset in the middle of a run, then a step that must do nothing
        tv.push_back(mk(1, 1, 0, 'h0010, 3, 1, 0, 0, 1, 'h0010, 1, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 'h0010, 3, 1, 0, 0, 1, 'h0000, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 1, 'h0010, 3, 1, 0, 0, 1, 'h0000, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 1, 'h0010, 3, 1, 0, 0, 1, 'h0000, 0, 0, 0, 0));
        foreach (tv[i]) begin
            put(tv[i].rn, tv[i].st, tv[i].sp, tv[i].ba, tv[i].l0, tv[i].s0, tv[i].l1, tv[i].s1);
            tick($sformatf("vec%0d", i), tv[i].ca, tv[i].ea, tv[i].ev, tv[i].el, tv[i].eb, tv[i].ed);
        end

        // stall: address holds while step is low
        put(1, 1, 0, 'h100, 2, 1, 1, 'h10);
        tick("stall_start", 1, 'h100, 1, 0, 1, 0);
        put(1, 0, 1, 'h100, 2, 1, 1, 'h10);
        tick("stall_step", 1, 'h101, 1, 0, 1, 0);
        put(1, 0, 0, 'h100, 2, 1, 1, 'h10);
        tick("stall_hold1", 1, 'h101, 1, 0, 1, 0);
        tick("stall_hold2", 1, 'h101, 1, 0, 1, 0);
        put(1, 0, 1, 'h100, 2, 1, 1, 'h10);
        seq = '{15'h102, 15'h110, 15'h111, 15'h112};
        for (int i = 0; i < 4; i++) tick($sformatf("stall_seq%0d", i), 1, seq[i], 1, i == 3, 1, 0);
        tick("stall_done", 0, 0, 0, 0, 1, 1);
        put(1, 0, 0, 'h100, 2, 1, 1, 'h10);
        tick("stall_idle", 0, 0, 0, 0, 0, 0);

        // single address sequence
        put(1, 1, 0, 'h42, 0, 0, 0, 0);
        tick("single_first", 1, 'h42, 1, 1, 1, 0);
        put(1, 0, 1, 'h42, 0, 0, 0, 0);
        tick("single_done", 0, 0, 0, 0, 1, 1);
        put(1, 0, 0, 'h42, 0, 0, 0, 0);
        tick("single_idle", 0, 0, 0, 0, 0, 0);

        // start and config changes while busy are ignored
        put(1, 1, 0, 'h100, 2, 1, 1, 'h10);
        tick("busy_start", 1, 'h100, 1, 0, 1, 0);
        put(1, 1, 1, 'h500, 0, 5, 0, 5);
        seq = '{15'h101, 15'h102, 15'h110, 15'h111};
        for (int i = 0; i < 4; i++) tick($sformatf("busy_seq%0d", i), 1, seq[i], 1, 0, 1, 0);
        tick("busy_last", 1, 'h112, 1, 1, 1, 0);
        tick("busy_done", 0, 0, 0, 0, 1, 1);
        put(1, 0, 0, 'h500, 2, 1, 1, 'h10);
        tick("busy_idle", 0, 0, 0, 0, 0, 0);

        // start with step in IDLE: new base, inner count from zero
        put(1, 1, 1, 'h500, 2, 1, 1, 'h10);
        tick("both_start", 1, 'h500, 1, 0, 1, 0);
        put(1, 0, 1, 'h500, 2, 1, 1, 'h10);
        seq = '{15'h501, 15'h502, 15'h510, 15'h511};
        for (int i = 0; i < 4; i++) tick($sformatf("both_seq%0d", i), 1, seq[i], 1, 0, 1, 0);
        tick("both_last", 1, 'h512, 1, 1, 1, 0);
        tick("both_done", 0, 0, 0, 0, 1, 1);
        put(1, 0, 0, 'h500, 2, 1, 1, 'h10);
        tick("both_idle", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/inagu.md
Name: inagu

Overview:
Input data memory read address generation unit. It produces the read address sequence the MVU uses to fetch input activations from the local data memory bank. It is the read-side counterpart of the output write address unit. It walks a two-level nested loop with programmable strides: an inner loop over words and an outer loop over rows. It advances one address per accepted `step` from the MVU datapath and signals end-of-sequence.

Parameters:
BDBANKA, 15, data bank address width in bits
BCNT, 8, loop counter width in bits; lengths are encoded as count-1

Ports:
clk  input  1  clock; all logic is on the rising edge
clr_n  input  1  synchronous active-low reset
start  input  1  launch a sequence; latches baseaddr, len0, stride0, len1, stride1
step  input  1  consumer accepted current addrout; advance to the next address
baseaddr  input  BDBANKA  first address of the sequence
len0  input  BCNT  inner loop iterations minus 1
stride0  input  BDBANKA  address increment between inner iterations
len1  input  BCNT  outer loop iterations minus 1
stride1  input  BDBANKA  address increment between outer row bases
addrout  output  BDBANKA  current read address
valid  output  1  addrout is meaningful and may be consumed
last  output  1  addrout is the final address of the sequence
busy  output  1  a sequence is in progress; high in RUN and DONE
done  output  1  one-cycle pulse after the final address is consumed

Behaviour:
- Reset (clr_n=0 at a clock edge), including mid-sequence: state goes to IDLE; addrout, rowbase, cnt0 and cnt1 go to 0; valid, last, busy and done go to 0. Reset has priority over all other inputs.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 latches all five config inputs, sets addrout=rowbase=baseaddr and cnt0=cnt1=0, and moves to RUN.
  - valid rises the cycle after start (latency 1).
  - step is ignored in IDLE.
- RUN:
  - valid=1. last = (cnt0==len0 && cnt1==len1) using the latched lengths.
  - step=1 and not last, with cnt0<len0: cnt0++, addrout <= addrout+stride0.
  - step=1 and not last, with cnt0==len0: cnt0 <= 0, cnt1++, rowbase <= rowbase+stride1, addrout <= rowbase+stride1.
  - step=1 and last: move to DONE; valid drops next cycle.
  - step=0: all state holds; addrout is stable indefinitely.
- DONE: done=1 and valid=0 for exactly one cycle, then IDLE. busy is high in RUN and DONE.
- start while busy is ignored; it neither restarts the sequence nor changes the latched config.
- start and step asserted in the same cycle in IDLE: start wins and step is ignored.
- Config inputs are sampled only on an accepted start. Changing them during RUN has no effect.
- All address arithmetic is modulo 2^BDBANKA; wrap-around past the top of the bank is legal and silent.
- len0=len1=0 gives a single address: last=1 in the first valid cycle.
- Sequence length = (len0+1)*(len1+1) addresses, with exactly one address per step. No bubbles while step is held high.
- stride0=0 or stride1=0 is legal; the address repeats accordingly.

Decomposition:
- Shared package holds:
  - the BDBANKA and BCNT defaults;
  - the state encoding constants for IDLE, RUN and DONE, shared with the outagu so MVU control decodes both identically.
- One natural sub-module, inagu_loopcnt: a BCNT-bit counter with clear, load-zero, increment enable and a wrap flag (cnt==len). It is instantiated twice, once for the inner and once for the outer loop.
- The top level holds the FSM, rowbase and the address adders.

Test Plan:
1. Reset mid-RUN: clr_n=0 for one cycle while in RUN with addrout=0x0010 -> next cycle addrout=0, valid=0, busy=0, state IDLE; a step afterwards has no effect.
2. Nested walk: baseaddr=0x0100, len0=2, stride0=1, len1=1, stride1=0x10, step held high -> addrout sequence 0x100, 0x101, 0x102, 0x110, 0x111, 0x112 on consecutive cycles. last=1 only on 0x112; done pulses one cycle after it; busy falls the cycle after done.
3. Stall: same config, step toggled 1,0,0,1 -> addrout holds 0x101 across the two stall cycles and valid stays 1.
4. Wrap: baseaddr=0x7FFE, len0=3, stride0=1, len1=0 -> sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001 with last on 0x0001.
5. Single address: len0=len1=0, baseaddr=0x0042 -> valid and last together in the first cycle with addrout=0x0042; one step -> done pulse.
6. start during RUN with baseaddr=0x0500 -> ignored; the original sequence completes unchanged. start and step together in IDLE -> sequence begins at the new baseaddr with cnt0=0.
